// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the sequencer state encoding and the counter width calculation.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // Width needed to count 0 .. max(a,b,c)-1, never narrower than one bit.
    function automatic int CNT_W(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Both flops clear to 0 on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for qualified lock with
// retries on timeout, then releases the system reset. Runs on refclk only.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_count
);

    localparam int CW = CNT_W(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [2:0]    MAX_R        = 3'(MAX_RETRIES);

    pll_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    retry_q, retry_d;
    logic          pll_rst_q, sys_rst_q, ready_q, fail_q;
    logic          locked_s;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = cnt_q + 1'b1;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == MAX_R) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                // A dropout restarts the lock wait without charging a retry.
                if (!locked_s)                 state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s || relock_req) begin
                    retry_d = 3'd0;
                    state_d = RESET_PLL;
                end
            end
            FAIL: begin
                cnt_d = '0;
                if (relock_req) begin
                    retry_d = 3'd0;
                    state_d = RESET_PLL;
                end
            end
            default: begin
                retry_d = 3'd0;
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so each changes on the entry edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= 3'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == RESET_PLL);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fail_q    <= (state_d == FAIL);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: table-driven sequence, corner-case
// sequences, and randomized stimulus against a timestamp-based reference model.
module tb_pll_reset_ctrl;

    localparam int RST_P = 4;
    localparam int TO    = 20;
    localparam int ST    = 8;
    localparam int MAXR  = 2;

    // Expected output words: {pll_rst, sys_rst, ready, fail, retry_count[2:0]}
    localparam logic [6:0] X_RST   = 7'b1100_000;
    localparam logic [6:0] X_WAIT  = 7'b0100_000;
    localparam logic [6:0] X_RUN   = 7'b0010_000;
    localparam logic [6:0] X_RST1  = 7'b1100_001;
    localparam logic [6:0] X_WAIT1 = 7'b0100_001;
    localparam logic [6:0] X_RST2  = 7'b1100_010;
    localparam logic [6:0] X_WAIT2 = 7'b0100_010;
    localparam logic [6:0] X_FAIL2 = 7'b0101_010;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [2:0] retry_count;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    pll_reset_ctrl #(
        .RST_PULSE_CYCLES    (RST_P),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    always #5 refclk = ~refclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] outs();
        return {pll_rst, sys_rst, ready, fail, retry_count};
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d actual=%b required=%b (pll_rst,sys_rst,ready,fail,retry)",
                     name, edge_n, act, exp);
        end
    endtask

    // ---------------- reference model (phase + entry timestamp) ----------------
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
    int   m_phase, m_entry, m_retry, m_n;
    logic m_hist[$];

    task automatic model_reset();
        m_phase = P_RST;
        m_entry = 0;
        m_retry = 0;
        m_n     = 0;
        m_hist.delete();
    endtask

    task automatic model_step(input logic l, input logic r);
        logic ls;
        int   elapsed;
        m_n++;
        // Decision at edge n uses pll_locked as sampled two edges earlier.
        ls = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 1'b0;
        m_hist.push_back(l);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        elapsed = m_n - m_entry;
        case (m_phase)
            P_RST:  if (elapsed == RST_P) begin m_phase = P_WAIT; m_entry = m_n; end
            P_WAIT: begin
                if (ls) begin
                    m_phase = P_STAB; m_entry = m_n;
                end else if (elapsed == TO) begin
                    if (m_retry == MAXR) begin
                        m_phase = P_FAIL; m_entry = m_n;
                    end else begin
                        m_retry++; m_phase = P_RST; m_entry = m_n;
                    end
                end
            end
            P_STAB: begin
                if (!ls)               begin m_phase = P_WAIT; m_entry = m_n; end
                else if (elapsed == ST) begin m_phase = P_RUN; m_entry = m_n; end
            end
            P_RUN:  if (!ls || r) begin m_phase = P_RST; m_retry = 0; m_entry = m_n; end
            default: if (r)       begin m_phase = P_RST; m_retry = 0; m_entry = m_n; end
        endcase
    endtask

    function automatic logic [6:0] model_outs();
        return {m_phase == P_RST, m_phase != P_RUN, m_phase == P_RUN,
                m_phase == P_FAIL, 3'(m_retry)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic l0);
        rst        = 1'b1;
        pll_locked = l0;
        relock_req = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        chk("reset_state", outs(), X_RST);
        rst    = 1'b0;
        edge_n = 0;
        model_reset();
    endtask

    task automatic tick(input logic l, input logic r);
        pll_locked = l;
        relock_req = r;
        @(posedge refclk);
        #1;
        edge_n++;
    endtask

    typedef struct {
        int         reps;
        logic       l;
        logic       r;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        int         at;
        logic [6:0] exp;
    } point_t;

    vec_t   tbl[$];
    point_t pts[$];

    initial begin
        // Nominal lock, lock loss in RUN, relock request in RUN and in WAIT_LOCK.
        tbl.push_back('{3,  1'b0, 1'b0, X_RST});
        tbl.push_back('{5,  1'b0, 1'b0, X_WAIT});
        tbl.push_back('{10, 1'b1, 1'b0, X_WAIT});
        tbl.push_back('{3,  1'b1, 1'b0, X_RUN});
        tbl.push_back('{2,  1'b0, 1'b0, X_RUN});
        tbl.push_back('{4,  1'b0, 1'b0, X_RST});
        tbl.push_back('{1,  1'b0, 1'b0, X_WAIT});
        tbl.push_back('{10, 1'b1, 1'b0, X_WAIT});
        tbl.push_back('{2,  1'b1, 1'b0, X_RUN});
        tbl.push_back('{1,  1'b1, 1'b1, X_RST});
        tbl.push_back('{3,  1'b1, 1'b0, X_RST});
        tbl.push_back('{1,  1'b1, 1'b0, X_WAIT});
        tbl.push_back('{1,  1'b1, 1'b1, X_WAIT});
        tbl.push_back('{7,  1'b1, 1'b0, X_WAIT});
        tbl.push_back('{2,  1'b1, 1'b0, X_RUN});

        do_reset(1'b0);
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                tick(tbl[i].l, tbl[i].r);
                chk($sformatf("table_row%0d", i), outs(), tbl[i].exp);
            end
        end

        // No lock: three pulses, retries 0->1->2, then FAIL; relock recovers.
        pts.push_back('{3,  X_RST});   pts.push_back('{4,  X_WAIT});
        pts.push_back('{23, X_WAIT});  pts.push_back('{24, X_RST1});
        pts.push_back('{27, X_RST1});  pts.push_back('{28, X_WAIT1});
        pts.push_back('{47, X_WAIT1}); pts.push_back('{48, X_RST2});
        pts.push_back('{51, X_RST2});  pts.push_back('{52, X_WAIT2});
        pts.push_back('{71, X_WAIT2}); pts.push_back('{72, X_FAIL2});
        pts.push_back('{80, X_FAIL2});
        do_reset(1'b0);
        for (int e = 1; e <= 80; e++) begin
            tick(1'b0, 1'b0);
            foreach (pts[j])
                if (pts[j].at == edge_n) chk($sformatf("nolock_e%0d", edge_n), outs(), pts[j].exp);
        end
        tick(1'b0, 1'b1);
        chk("fail_relock", outs(), X_RST);
        tick(1'b0, 1'b0);
        chk("fail_relock_hold", outs(), X_RST);

        // Glitchy lock: high 5, low 1, then high; RUN only after a full stable run.
        do_reset(1'b0);
        for (int e = 1; e <= 22; e++) begin
            tick((e >= 5 && e <= 9) || e >= 11, 1'b0);
            if (edge_n == 15) chk("glitch_no_early_run", outs(), X_WAIT);
            if (edge_n == 20) chk("glitch_not_yet", outs(), X_WAIT);
            if (edge_n == 21) chk("glitch_run", outs(), X_RUN);
        end

        // Asynchronous reset mid-STABLE and mid-RUN, between clock edges.
        do_reset(1'b1);
        for (int e = 1; e <= 8; e++) tick(1'b1, 1'b0);
        chk("pre_async_stable", outs(), X_WAIT);
        #2 rst = 1'b1;
        #1 chk("async_rst_stable", outs(), X_RST);
        do_reset(1'b1);
        for (int e = 1; e <= 13; e++) tick(1'b1, 1'b0);
        chk("pre_async_run", outs(), X_RUN);
        #2 rst = 1'b1;
        #1 chk("async_rst_run", outs(), X_RST);

        // Randomized segments of lock/no-lock plus sporadic relock requests.
        do_reset(1'b0);
        begin
            logic l, r;
            int   seg_left;
            l = 1'b0;
            seg_left = 0;
            for (int i = 0; i < 3000; i++) begin
                if (seg_left == 0) begin
                    l = 1'($urandom_range(0, 1));
                    seg_left = $urandom_range(1, 120);
                end
                seg_left--;
                r = ($urandom_range(0, 39) == 0);
                model_step(l, r);
                tick(l, r);
                chk("random", outs(), model_outs());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer on the other end of the PLL's `rst`/`locked` interface. It drives the PLL reset, watches the asynchronous `locked` output, and retries on lock timeout. Once lock has been stable for a qualified period, it releases a system reset for the core clock domains. It runs on the 50 MHz board reference clock, so it never depends on a PLL output clock.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, default 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 50000: cycles allowed for lock after `pll_rst` falls (1 ms at 50 MHz).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before release.
- `MAX_RETRIES`, default 7: PLL reset re-attempts before declaring failure (fits `retry_count`).

Ports:
- `refclk` in 1: sole clock, 50 MHz board reference.
- `rst` in 1: asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle request to re-run the full lock sequence (e.g. after PLL reconfig).
- `pll_rst` out 1: reset to PLL, registered.
- `sys_rst` out 1: active-high reset for downstream logic, registered.
- `ready` out 1: high in RUN only.
- `fail` out 1: high in FAIL only.
- `retry_count` out 3: retries consumed in the current sequence.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. All decisions use `locked_s`.
- One counter `cnt`, width `$clog2` of the largest cycle parameter. It clears on every state change.
- RESET_PLL: `pll_rst`=1, `sys_rst`=1. When `cnt`==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=1 → STABLE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT_CYCLES-1:
    - if `retry_count`==MAX_RETRIES → FAIL;
    - else `retry_count`++ and go to RESET_PLL.
- STABLE: `sys_rst`=1.
  - `locked_s`=0 → WAIT_LOCK, with the timeout restarted and no retry charged.
  - When `cnt`==LOCK_STABLE_CYCLES-1 → RUN.
- RUN: `sys_rst`=0, `ready`=1.
  - `locked_s`=0 → RESET_PLL, `retry_count` cleared (lock loss starts a fresh sequence).
  - `relock_req` → RESET_PLL, `retry_count` cleared.
- FAIL: `pll_rst`=0, `sys_rst`=1, `fail`=1.
  - Exit only via `relock_req` (→ RESET_PLL, `retry_count` cleared) or `rst`.
- `relock_req` is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- Simultaneous lock loss and `relock_req` in RUN gives the same result: RESET_PLL.
- No output depends combinationally on any input.

## Timing
- Reset values: state RESET_PLL, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `retry_count`=0, synchronizer flops 0.
- Outputs are Moore and registered. Each output changes on the same edge that enters its state.
- `pll_rst` is high for exactly RST_PULSE_CYCLES edges after `rst` release, and on each retry.
- Synchronizer latency: 2 cycles from a `pll_locked` edge to a `locked_s` change.
- Lock to release: minimum 2 + 1 + LOCK_STABLE_CYCLES cycles from `pll_locked` rising to `sys_rst` falling.
- Lock loss in RUN: `sys_rst` rises and `ready` falls exactly 3 cycles after `pll_locked` falls (2 sync + 1 register).
- Lock timeout fires LOCK_TIMEOUT_CYCLES cycles after entering WAIT_LOCK.
- `rst` asserted mid-sequence: all outputs return asynchronously to reset values, without waiting for a clock edge.

## Structure
- `pll_ctrl_pkg`: state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL) and a `CNT_W` helper function.
- Sub-module `sync_2ff` (1-bit, async reset to 0) for `pll_locked`. It is reusable for other async status inputs.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal: release `rst`, raise `pll_locked` 5 cycles after `pll_rst` falls → `pll_rst` high 4 cycles; `sys_rst` falls and `ready` rises 11 cycles after the `pll_locked` rise; `retry_count`=0.
- No lock: hold `pll_locked`=0 → three `pll_rst` pulses of 4 cycles, each after 20 low cycles; `retry_count` steps 0→1→2; `fail`=1 on the third timeout; `sys_rst` stays 1.
- Glitchy lock: `pll_locked` high 5 cycles, low 1, then high → no RUN until 8 consecutive `locked_s` cycles; no `retry_count` increment.
- Lock loss in RUN: drop `pll_locked` → `sys_rst`=1 and `ready`=0 after 3 cycles; `pll_rst` pulses 4 cycles; relock reaches RUN with `retry_count`=0.
- Recovery: in FAIL, pulse `relock_req` → `fail`=0 next cycle, `pll_rst`=1, `retry_count`=0. Same pulse during WAIT_LOCK → no effect.
- Async reset: assert `rst` mid-STABLE between clock edges → `pll_rst`=1, `sys_rst`=1, `ready`=0 immediately.
